// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: programmable clock-enable divider. Produces a divided
// square-wave enable and a period-start strobe. New divide ratios arrive
// through a valid/ready handshake and are applied only at a period boundary
// (or when the divider stops), so a running period is never truncated.
module freq_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] div_cur_nxt;
  logic [CNT_W-1:0] div_pend;
  logic [CNT_W-1:0] div_pend_nxt;
  logic             cfg_err_nxt;

  logic             xfer;
  logic             xfer_ok;
  logic             xfer_bad;
  logic             wrap;

  // A ratio below 2 cannot form a period with both a high and a low phase.
  function automatic logic ratio_legal(input logic [CNT_W-1:0] r);
    return (r >= TWO);
  endfunction

  // True on the last cycle of a period of length d (d >= 2 is guaranteed,
  // so d - 1 never underflows).
  function automatic logic period_last(input logic [CNT_W-1:0] c,
                                       input logic [CNT_W-1:0] d);
    return (c == (d - ONE));
  endfunction

  assign xfer     = cfg_valid && cfg_ready;
  assign xfer_ok  = xfer && ratio_legal(cfg_div);
  assign xfer_bad = xfer && !ratio_legal(cfg_div);
  assign wrap     = period_last(cnt, div_cur);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: stop has priority over everything, PEND returns to
  // RUN only at the end of the current period.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en)          state_nxt = IDLE;
        else if (xfer_ok) state_nxt = PEND;
      end
      PEND: begin
        if (!en)       state_nxt = IDLE;
        else if (wrap) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the counter and ratio registers, following the state
  // transitions above.
  always_comb begin
    cnt_nxt      = cnt;
    div_cur_nxt  = div_cur;
    div_pend_nxt = div_pend;
    cfg_err_nxt  = xfer_bad;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (xfer_ok) div_cur_nxt = cfg_div;
      end
      RUN: begin
        if (!en) begin
          // Stopping: a ratio offered on the same edge becomes current.
          cnt_nxt = '0;
          if (xfer_ok) div_cur_nxt = cfg_div;
        end else begin
          cnt_nxt = wrap ? '0 : cnt + ONE;
          if (xfer_ok) div_pend_nxt = cfg_div;
        end
      end
      PEND: begin
        if (!en || wrap) begin
          cnt_nxt     = '0;
          div_cur_nxt = div_pend;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

  // Counter, ratio and error registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt      <= '0;
      div_cur  <= DEF_DIV_V;
      div_pend <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      div_cur  <= div_cur_nxt;
      div_pend <= div_pend_nxt;
      cfg_err  <= cfg_err_nxt;
    end
  end

  // Outputs decoded from registers only: high phase is floor(N/2) cycles.
  always_comb begin
    busy      = (state != IDLE);
    cfg_ready = (state != PEND);
    tick      = busy && (cnt == '0);
    div_out   = busy && (cnt < (div_cur >> 1));
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: directed scenarios, a period/phase model of the
// divider checked every cycle, and literal waveform expectations.
module tb_freq_div_ctrl;

  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 3;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             div_out;
  logic             tick;
  logic             busy;

  int n_cmp;
  int n_bad;

  freq_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .tick      (tick),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a running flag, position within the period, current ratio and a
  // queue holding at most one accepted-but-not-yet-applied ratio.
  bit m_ok;
  bit m_run;
  bit m_err;
  int m_phase;
  int m_ratio;
  int m_pend[$];
  bit m_xfer;
  bit m_legal;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_ok    = 1'b1;
      m_run   = 1'b0;
      m_err   = 1'b0;
      m_phase = 0;
      m_ratio = DEF_DIV;
      m_pend.delete();
    end else if (m_ok) begin
      m_xfer  = cfg_valid && (m_pend.size() == 0);
      m_legal = int'(cfg_div) >= 2;
      m_err   = m_xfer && !m_legal;
      if (!m_run) begin
        if (m_xfer && m_legal) m_ratio = int'(cfg_div);
        if (en) begin
          m_run   = 1'b1;
          m_phase = 0;
        end
      end else if (!en) begin
        if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
        else if (m_xfer && m_legal) m_ratio = int'(cfg_div);
        m_run   = 1'b0;
        m_phase = 0;
      end else begin
        if (m_phase == m_ratio - 1) begin
          m_phase = 0;
          if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
        end else begin
          m_phase = m_phase + 1;
        end
        if (m_xfer && m_legal) m_pend.push_back(int'(cfg_div));
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      check("busy",      32'(busy),      32'(m_run));
      check("tick",      32'(tick),      32'(m_run && m_phase == 0));
      check("div_out",   32'(div_out),   32'(m_run && m_phase < m_ratio / 2));
      check("cfg_ready", 32'(cfg_ready), 32'(m_pend.size() == 0));
      check("cfg_err",   32'(cfg_err),   32'(m_err));
    end
  end

  // Sample div_out/tick for n cycles starting at the current negedge.
  task automatic collect(input int n, output logic [15:0] d,
                         output logic [15:0] t);
    d = '0;
    t = '0;
    for (int i = 0; i < n; i++) begin
      d[n-1-i] = div_out;
      t[n-1-i] = tick;
      @(negedge clk);
    end
  endtask

  logic [15:0] d_seq;
  logic [15:0] t_seq;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    m_ok      = 1'b0;
    reset_n   = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_div_out",   32'(div_out),   32'd0);
    check("rst_tick",      32'(tick),      32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);

    // 1: default ratio 3
    reset_n = 1'b1;
    en      = 1'b1;
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd1);
    collect(6, d_seq, t_seq);
    check("t1_div_seq",  32'(d_seq), 32'b100100);
    check("t1_tick_seq", 32'(t_seq), 32'b100100);

    // 2: ratio 4 loaded and started on the same edge
    en = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    en        = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t2_cfg_ready", 32'(cfg_ready), 32'd1);
    collect(8, d_seq, t_seq);
    check("t2_div_seq",  32'(d_seq), 32'b11001100);
    check("t2_tick_seq", 32'(t_seq), 32'b10001000);

    // 3: running 3, accept 5 at cnt=0
    en = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    en        = 1'b1;
    @(negedge clk);
    cfg_div = 8'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t3_ready_cnt1", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    check("t3_ready_cnt2", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    check("t3_ready_tick", 32'(cfg_ready), 32'd1);
    collect(10, d_seq, t_seq);
    check("t3_div_seq",  32'(d_seq), 32'b1100011000);
    check("t3_tick_seq", 32'(t_seq), 32'b1000010000);

    // 4: illegal ratios 1 and 0 while running with 5
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t4_err1",   32'(cfg_err),   32'd1);
    check("t4_ready1", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    check("t4_err1_end", 32'(cfg_err), 32'd0);
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t4_err0",   32'(cfg_err),   32'd1);
    check("t4_ready0", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    check("t4_err0_end", 32'(cfg_err), 32'd0);
    @(negedge clk);
    check("t4_tick_keep5", 32'(tick), 32'd1);

    // 5: pending 6, stop at cnt=1, restart
    en = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    en        = 1'b1;
    @(negedge clk);
    cfg_div = 8'd6;
    @(negedge clk);
    cfg_valid = 1'b0;
    en        = 1'b0;
    @(negedge clk);
    check("t5_busy",    32'(busy),    32'd0);
    check("t5_div_out", 32'(div_out), 32'd0);
    check("t5_tick",    32'(tick),    32'd0);
    en = 1'b1;
    @(negedge clk);
    collect(12, d_seq, t_seq);
    check("t5_div_seq",  32'(d_seq), 32'b111000111000);
    check("t5_tick_seq", 32'(t_seq), 32'b100000100000);

    // 6: reset while pending 7
    en = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    en        = 1'b1;
    @(negedge clk);
    cfg_div = 8'd7;
    @(negedge clk);
    check("t6_pend_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    reset_n   = 1'b0;
    en        = 1'b0;
    @(negedge clk);
    check("t6_busy",  32'(busy),      32'd0);
    check("t6_ready", 32'(cfg_ready), 32'd1);
    reset_n = 1'b1;
    en      = 1'b1;
    @(negedge clk);
    collect(6, d_seq, t_seq);
    check("t6_div_seq",  32'(d_seq), 32'b100100);
    check("t6_tick_seq", 32'(t_seq), 32'b100100);

    // 7: ratio 4 accepted on the wrap edge of a 3-period
    @(negedge clk);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t7_ready", 32'(cfg_ready), 32'd0);
    collect(11, d_seq, t_seq);
    check("t7_div_seq",  32'(d_seq), 32'b10011001100);
    check("t7_tick_seq", 32'(t_seq), 32'b10010001000);

    en = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
